// File: rtl/reg_check_harness.sv
// Register-file check harness: logs writeback events into a trace FIFO for a
// bounded run, then scans the regfile read port against an expected-value memory.
module reg_check_harness #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CYC_W-1:0]  num_cycles_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              test_mode_o,
  output logic [REG_AW-1:0] test_rs_o,
  input  logic [DATA_W-1:0] test_rdata_i,
  output logic [REG_AW-1:0] exp_addr_o,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic              trace_rd_en_i,
  output logic              trace_valid_o,
  output logic [CYC_W-1:0]  trace_cycle_o,
  output logic [REG_AW-1:0] trace_rd_o,
  output logic [DATA_W-1:0] trace_data_o,
  output logic              trace_overflow_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [REG_AW:0]   err_count_o,
  output logic              fail_valid_o,
  output logic [REG_AW-1:0] fail_reg_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int TAW      = $clog2(TRACE_DEPTH);
  localparam int TW       = CYC_W + REG_AW + DATA_W;
  localparam logic [REG_AW:0] ERR_MAX  = (REG_AW + 1)'(NUM_REGS);
  localparam logic [TAW:0]    FIFO_MAX = (TAW + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CYC_W-1:0]  len_q, len_d;
  logic [REG_AW:0]   scan_cnt_q, scan_cnt_d;
  logic [REG_AW:0]   err_q, err_d;
  logic              rdy_q;
  logic              cmp_vld_q;
  logic [REG_AW-1:0] cmp_idx_q;
  logic [DATA_W-1:0] act_q;
  logic [TAW:0]      wptr_q, rptr_q;
  logic              ovf_q;
  logic [TW-1:0]     mem_q [TRACE_DEPTH];

  logic start_acc, scan_issue, mismatch;
  logic empty, full, push_req, push, pop;
  logic [TW-1:0] head;

  // rdy_q keeps a start seen on the reset-release edge from being accepted.
  assign start_acc  = start_i && rdy_q && (state_q == S_IDLE || state_q == S_DONE);
  assign scan_issue = (state_q == S_SCAN) && !scan_cnt_q[REG_AW];
  assign mismatch   = cmp_vld_q && (exp_data_i != act_q);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    len_d      = len_q;
    scan_cnt_d = scan_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          len_d      = num_cycles_i;
          cyc_d      = '0;
          err_d      = '0;
          scan_cnt_d = '0;
          state_d    = (num_cycles_i == '0) ? S_SCAN : S_RUN;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == len_q - 1'b1) state_d = S_SCAN;
      end
      S_SCAN: begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        if (scan_cnt_q[REG_AW]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (mismatch && err_q != ERR_MAX) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      len_q      <= '0;
      scan_cnt_q <= '0;
      err_q      <= '0;
      rdy_q      <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_idx_q  <= '0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      len_q      <= len_d;
      scan_cnt_q <= scan_cnt_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
      cmp_vld_q  <= scan_issue;
      if (scan_issue) begin
        cmp_idx_q <= scan_cnt_q[REG_AW-1:0];
        act_q     <= test_rdata_i;
      end
    end
  end

  // Trace FIFO; a full FIFO still accepts a push when the head is popped the same cycle.
  assign empty    = (wptr_q == rptr_q);
  assign full     = ((wptr_q - rptr_q) == FIFO_MAX);
  assign push_req = (state_q == S_RUN) && wb_we_i && (wb_rd_i != '0);
  assign pop      = trace_rd_en_i && !empty;
  assign push     = push_req && (!full || pop);
  assign head     = mem_q[rptr_q[TAW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else if (start_acc) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[TAW-1:0]] <= {cyc_q, wb_rd_i, wb_data_i};
  end

  assign test_mode_o      = (state_q == S_SCAN);
  assign test_rs_o        = scan_issue ? scan_cnt_q[REG_AW-1:0] : '0;
  assign exp_addr_o       = scan_issue ? scan_cnt_q[REG_AW-1:0] : '0;
  assign trace_valid_o    = !empty;
  assign trace_cycle_o    = empty ? '0 : head[TW-1 -: CYC_W];
  assign trace_rd_o       = empty ? '0 : head[DATA_W +: REG_AW];
  assign trace_data_o     = empty ? '0 : head[DATA_W-1:0];
  assign trace_overflow_o = ovf_q;
  assign busy_o           = (state_q == S_RUN) || (state_q == S_SCAN);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = (state_q == S_DONE) && (err_q == '0);
  assign err_count_o      = err_q;
  assign fail_valid_o     = mismatch;
  assign fail_reg_o       = mismatch ? cmp_idx_q : '0;
  assign fail_exp_o       = mismatch ? exp_data_i : '0;
  assign fail_act_o       = mismatch ? act_q : '0;
endmodule

// File: tb/tb_reg_check_harness.sv
// Scoreboard bench for reg_check_harness: trace entries and mismatch reports are
// queued as stimulus is applied and compared as the design produces them.
module tb_reg_check_harness;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_cycles;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        test_mode;
  logic [4:0]  test_rs;
  logic [31:0] test_rdata;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        trace_rd_en;
  logic        trace_valid;
  logic [15:0] trace_cycle;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic        fail_valid;
  logic [4:0]  fail_reg;
  logic [31:0] fail_exp, fail_act;

  logic [31:0] rf   [32];
  logic [31:0] expm [32];
  logic [52:0] tq [$];
  logic [68:0] fq [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign test_rdata = rf[test_rs];
  always @(posedge clk) exp_data <= expm[exp_addr];

  reg_check_harness dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_cycles_i(num_cycles),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .test_mode_o(test_mode), .test_rs_o(test_rs), .test_rdata_i(test_rdata),
    .exp_addr_o(exp_addr), .exp_data_i(exp_data),
    .trace_rd_en_i(trace_rd_en), .trace_valid_o(trace_valid),
    .trace_cycle_o(trace_cycle), .trace_rd_o(trace_rd), .trace_data_o(trace_data),
    .trace_overflow_o(trace_overflow), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .fail_valid_o(fail_valid), .fail_reg_o(fail_reg),
    .fail_exp_o(fail_exp), .fail_act_o(fail_act)
  );

  task automatic set_mem();
    for (int i = 0; i < 32; i++) begin
      rf[i]   = $urandom;
      expm[i] = rf[i];
    end
  endtask

  task automatic start_run(input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    num_cycles = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain_trace(input string name);
    logic [52:0] e;
    int guard = 0;
    while (trace_valid && guard < 64) begin
      n_cmp++;
      if (tq.size() == 0) begin
        n_err++;
        $display("FAIL %s extra: got {%0d,%0d,%0h} expected none", name, trace_cycle, trace_rd, trace_data);
      end else begin
        e = tq.pop_front();
        if ({trace_cycle, trace_rd, trace_data} !== e) begin
          n_err++;
          $display("FAIL %s entry: got {%0d,%0d,%0h} expected {%0d,%0d,%0h}", name,
                   trace_cycle, trace_rd, trace_data, e[52:37], e[36:32], e[31:0]);
        end
      end
      trace_rd_en = 1'b1;
      @(negedge clk);
      trace_rd_en = 1'b0;
      guard++;
    end
    n_cmp++;
    if (tq.size() != 0 || trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s drain: got valid=%0b left=%0d expected valid=0 left=0", name, trace_valid, tq.size());
    end
    tq.delete();
  endtask

  task automatic wait_done(input string name, input int exp_scan);
    logic [68:0] e;
    int scan_cyc = 0;
    bit seen = 0;
    bit rs_bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (test_mode) scan_cyc++;
      else if (test_rs !== 5'd0 || exp_addr !== 5'd0) rs_bad = 1;
      if (fail_valid === 1'b1) begin
        n_cmp++;
        if (fq.size() == 0) begin
          n_err++;
          $display("FAIL %s fail_report: got reg %0d expected none", name, fail_reg);
        end else begin
          e = fq.pop_front();
          if ({fail_reg, fail_exp, fail_act} !== e) begin
            n_err++;
            $display("FAIL %s fail_report: got {%0d,%0h,%0h} expected {%0d,%0h,%0h}", name,
                     fail_reg, fail_exp, fail_act, e[68:64], e[63:32], e[31:0]);
          end
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || scan_cyc != exp_scan || fq.size() != 0 || rs_bad || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s scan: got done=%0b scan_cycles=%0d missing_reports=%0d rs_bad=%0b busy=%0b expected 1/%0d/0/0/0",
               name, seen, scan_cyc, fq.size(), rs_bad, busy, exp_scan);
    end
    fq.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({busy, done, pass, test_mode, fail_valid, err_count, trace_overflow, trace_valid,
         test_rs, exp_addr} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: got busy=%0b done=%0b pass=%0b tm=%0b fv=%0b err=%0d ovf=%0b tv=%0b rs=%0d ea=%0d expected all 0",
               name, busy, done, pass, test_mode, fail_valid, err_count, trace_overflow, trace_valid, test_rs, exp_addr);
    end
  endtask

  task automatic check_result(input string name, input logic [5:0] e_err, input logic e_pass);
    n_cmp++;
    if (err_count !== e_err || pass !== e_pass || done !== 1'b1) begin
      n_err++;
      $display("FAIL %s result: got err=%0d pass=%0b done=%0b expected err=%0d pass=%0b done=1",
               name, err_count, pass, done, e_err, e_pass);
    end
  endtask

  task automatic wait_scan(input string name, input int k0, input int exp_k);
    int k = k0;
    while (!test_mode && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != exp_k) begin
      n_err++;
      $display("FAIL %s scan_start: got cycle %0d expected %0d", name, k, exp_k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; num_cycles = 16'd3;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; trace_rd_en = 1'b0;
    set_mem();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || test_mode !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_start: got busy=%0b tm=%0b expected 0/0", busy, test_mode);
    end
  endtask

  task automatic test_basic();
    set_mem();
    start_run(16'd5);
    n_cmp++;
    if (busy !== 1'b1 || test_mode !== 1'b0) begin
      n_err++;
      $display("FAIL basic_run_entry: got busy=%0b tm=%0b expected 1/0", busy, test_mode);
    end
    @(negedge clk);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
    tq.push_back({16'd1, 5'd3, 32'd7});
    @(negedge clk);
    wb_rd = 5'd0; wb_data = 32'd99;
    @(negedge clk);
    wb_we = 1'b0;
    wait_scan("basic", 3, 5);
    wait_done("basic", 33);
    check_result("basic", 6'd0, 1'b1);
    drain_trace("basic");
  endtask

  task automatic test_zero_len();
    set_mem();
    start_run(16'd0);
    n_cmp++;
    if (test_mode !== 1'b1) begin
      n_err++;
      $display("FAIL zero_len_scan: got tm=%0b expected 1", test_mode);
    end
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
    wait_done("zero_len", 33);
    wb_we = 1'b0;
    check_result("zero_len", 6'd0, 1'b1);
    n_cmp++;
    if (trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_trace: got valid=%0b expected 0", trace_valid);
    end
  endtask

  task automatic test_overflow();
    logic [52:0] e;
    logic [52:0] h;
    int cnt = 0;
    set_mem();
    start_run(16'd20);
    for (int k = 0; k < 18; k++) begin
      wb_we = 1'b1; wb_rd = 5'((k % 31) + 1); wb_data = $urandom;
      if (k < 16) tq.push_back({16'(k), wb_rd, wb_data});
      @(negedge clk);
    end
    wb_we = 1'b0;
    wait_done("ovf_nopop", 33);
    n_cmp++;
    if (trace_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_nopop_flag: got %0b expected 1", trace_overflow);
    end
    drain_trace("ovf_nopop");
    start_run(16'd20);
    n_cmp++;
    if (trace_overflow !== 1'b0 || trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got ovf=%0b valid=%0b expected 0/0", trace_overflow, trace_valid);
    end
    for (int k = 0; k < 20; k++) begin
      trace_rd_en = 1'b0;
      wb_we = 1'b1; wb_rd = 5'((k % 31) + 1); wb_data = $urandom;
      if (cnt == 16) begin
        e = tq.pop_front();
        h = {trace_cycle, trace_rd, trace_data};
        n_cmp++;
        if (trace_valid !== 1'b1 || h !== e) begin
          n_err++;
          $display("FAIL ovf_pop_head: got {%0d,%0d,%0h} expected {%0d,%0d,%0h}",
                   h[52:37], h[36:32], h[31:0], e[52:37], e[36:32], e[31:0]);
        end
        trace_rd_en = 1'b1;
        cnt--;
      end
      tq.push_back({16'(k), wb_rd, wb_data});
      cnt++;
      @(negedge clk);
    end
    trace_rd_en = 1'b0;
    wb_we = 1'b0;
    wait_done("ovf_pop", 33);
    n_cmp++;
    if (trace_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_pop_flag: got %0b expected 0", trace_overflow);
    end
    drain_trace("ovf_pop");
  endtask

  task automatic test_mismatch();
    set_mem();
    expm[5] = 32'd10; rf[5] = 32'd9;
    expm[31] = rf[31] ^ 32'h8000_0001;
    fq.push_back({5'd5, 32'd10, 32'd9});
    fq.push_back({5'd31, expm[31], rf[31]});
    start_run(16'd1);
    wait_done("mismatch", 33);
    check_result("mismatch", 6'd2, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    set_mem();
    rf[5] = expm[5] + 32'd1;
    start_run(16'd0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (err_count !== 6'd1 || test_mode !== 1'b1) begin
      n_err++;
      $display("FAIL midscan_pre: got err=%0d tm=%0b expected 1/1", err_count, test_mode);
    end
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rf[5] = expm[5];
    start_run(16'd0);
    wait_done("midscan_rerun", 33);
    check_result("midscan_rerun", 6'd0, 1'b1);
  endtask

  task automatic test_start_during_run();
    set_mem();
    start_run(16'd6);
    num_cycles = 16'd1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_scan("start_in_run", 3, 6);
    wait_done("start_in_run", 33);
    check_result("start_in_run", 6'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_mismatch();
    test_reset_mid_scan();
    test_start_during_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
